pipe_hazard_ctrl: RTL and testbench

Pipeline control unit for the 5-stage ARM core. It generates the per-stage `freeze`/`flush` controls for the PC/IF, ID/EX, EX/MEM and MEM/WB stage registers, including the `flush`/`freeze` pins of the ID/EX register. It combines three sources:
- data-hazard detection, which inserts a bubble;
- branch squash;
- a multi-cycle SRAM wait FSM, which freezes the whole pipeline while the MEM stage waits on memory.

It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_ctrl_pkg.sv | 11 +
 rtl/sram_wait_fsm.sv | 61 ++++++
 rtl/pipe_hazard_ctrl.sv | 87 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard/stall control slice.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/sram_wait_fsm.sv
// Multi-cycle SRAM wait sequencer: stalls MEM for SRAM_WAIT cycles per access,
// then pulses done for one cycle.
module sram_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_access,
  output logic mem_stall_c,
  output logic sram_done_c
);

  localparam int unsigned CLOG_W = $clog2(SRAM_WAIT);
  localparam int unsigned WCNT_W = (CLOG_W > 4) ? CLOG_W : 4;
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(SRAM_WAIT - 1);

  mem_state_e state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Stall/done are suppressed while rst is high so a reset aborts a wait at once.
  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    mem_stall_c = 1'b0;
    sram_done_c = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (mem_access) begin
            mem_stall_c = 1'b1;
            wcnt_nxt    = WCNT_LOAD;
            state_nxt   = WAIT;
          end
        end
        WAIT: begin
          if (wcnt != '0) begin
            mem_stall_c = 1'b1;
            wcnt_nxt    = wcnt - WCNT_W'(1);
          end else begin
            sram_done_c = 1'b1;
            state_nxt   = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline control: data-hazard bubble, branch squash and SRAM-wait
// freeze, prioritised into per-stage freeze/flush, plus a stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_WAIT = 4,
  parameter bit          FORWARD   = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic             id_src1_valid,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_wb_en,
  input  logic             ex_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_access,
  input  logic             branch_taken,
  output logic             if_freeze,
  output logic             if_flush,
  output logic             id_freeze,
  output logic             id_flush,
  output logic             ex_freeze,
  output logic             mem_freeze,
  output logic             sram_done,
  output logic             hazard,
  output logic [CNT_W-1:0] stall_cnt
);

  logic mem_stall;
  logic ex_hit, mem_hit;
  logic stall_evt;

  sram_wait_fsm #(
    .SRAM_WAIT(SRAM_WAIT)
  ) u_sram_wait_fsm (
    .clk        (clk),
    .rst        (rst),
    .mem_access (mem_access),
    .mem_stall_c(mem_stall),
    .sram_done_c(sram_done)
  );

  assign ex_hit  = ex_wb_en && ((id_src1_valid && (id_src1 == ex_dest)) ||
                                (id_two_src    && (id_src2 == ex_dest)));
  assign mem_hit = mem_wb_en && ((id_src1_valid && (id_src1 == mem_dest)) ||
                                 (id_two_src    && (id_src2 == mem_dest)));

  // With forwarding only a load in EX cannot be bypassed in time.
  assign hazard = FORWARD ? (ex_mem_r_en && ex_hit) : (ex_hit || mem_hit);

  always_comb begin
    if_freeze  = 1'b0;
    if_flush   = 1'b0;
    id_freeze  = 1'b0;
    id_flush   = 1'b0;
    ex_freeze  = 1'b0;
    mem_freeze = 1'b0;
    if (mem_stall) begin
      if_freeze  = 1'b1;
      id_freeze  = 1'b1;
      ex_freeze  = 1'b1;
      mem_freeze = 1'b1;
    end else if (branch_taken) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (hazard) begin
      if_freeze = 1'b1;
      id_flush  = 1'b1;
    end
  end

  assign stall_evt = mem_stall || (hazard && !branch_taken);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_evt && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three parameterisations against a behavioural model.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst;
  logic [3:0] id_src1, id_src2, ex_dest, mem_dest;
  logic id_src1_valid, id_two_src, ex_wb_en, ex_mem_r_en, mem_wb_en;
  logic mem_access, branch_taken;

  // {if_freeze, if_flush, id_freeze, id_flush, ex_freeze, mem_freeze, sram_done, hazard}
  logic [7:0]  o0, o1, o2;
  logic [15:0] c0, c1;
  logic [2:0]  c2;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  int m_k[3]   = '{-1, -1, -1};
  int m_cnt[3] = '{0, 0, 0};

  pipe_hazard_ctrl #(.SRAM_WAIT(4), .FORWARD(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src1_valid(id_src1_valid),
    .id_src2(id_src2), .id_two_src(id_two_src), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en),
    .ex_mem_r_en(ex_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_access(mem_access), .branch_taken(branch_taken),
    .if_freeze(o0[7]), .if_flush(o0[6]), .id_freeze(o0[5]), .id_flush(o0[4]),
    .ex_freeze(o0[3]), .mem_freeze(o0[2]), .sram_done(o0[1]), .hazard(o0[0]),
    .stall_cnt(c0));

  pipe_hazard_ctrl #(.SRAM_WAIT(2), .FORWARD(1'b0), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src1_valid(id_src1_valid),
    .id_src2(id_src2), .id_two_src(id_two_src), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en),
    .ex_mem_r_en(ex_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_access(mem_access), .branch_taken(branch_taken),
    .if_freeze(o1[7]), .if_flush(o1[6]), .id_freeze(o1[5]), .id_flush(o1[4]),
    .ex_freeze(o1[3]), .mem_freeze(o1[2]), .sram_done(o1[1]), .hazard(o1[0]),
    .stall_cnt(c1));

  pipe_hazard_ctrl #(.SRAM_WAIT(1), .FORWARD(1'b1), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src1_valid(id_src1_valid),
    .id_src2(id_src2), .id_two_src(id_two_src), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en),
    .ex_mem_r_en(ex_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_access(mem_access), .branch_taken(branch_taken),
    .if_freeze(o2[7]), .if_flush(o2[6]), .id_freeze(o2[5]), .id_flush(o2[4]),
    .ex_freeze(o2[3]), .mem_freeze(o2[2]), .sram_done(o2[1]), .hazard(o2[0]),
    .stall_cnt(c2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sw_of(int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
  endfunction

  function automatic bit fw_of(int i);
    return (i != 1);
  endfunction

  function automatic int cmax_of(int i);
    return (i == 2) ? 7 : 65535;
  endfunction

  function automatic bit hz_f(bit fw);
    bit e1, e2, m1, m2;
    e1 = id_src1_valid && ex_wb_en  && (id_src1 == ex_dest);
    e2 = id_two_src    && ex_wb_en  && (id_src2 == ex_dest);
    m1 = id_src1_valid && mem_wb_en && (id_src1 == mem_dest);
    m2 = id_two_src    && mem_wb_en && (id_src2 == mem_dest);
    if (fw) return ex_mem_r_en && (e1 || e2);
    return e1 || e2 || m1 || m2;
  endfunction

  // Position of the access in MEM this cycle: -1 none, 0..SW-1 stalled, SW done.
  function automatic int phase(int i);
    if (m_k[i] < 0) return mem_access ? 0 : -1;
    return m_k[i];
  endfunction

  function automatic logic [7:0] exp_out(int i);
    int ph;
    bit st, dn, hz;
    hz = hz_f(fw_of(i));
    ph = phase(i);
    st = !rst && (ph >= 0) && (ph < sw_of(i));
    dn = !rst && (ph == sw_of(i));
    if (st)                return {6'b101011, 1'b0, hz};
    else if (branch_taken) return {6'b010100, dn, hz};
    else if (hz)           return {6'b100100, dn, hz};
    return {6'b000000, dn, hz};
  endfunction

  function automatic logic [7:0] act_out(int i);
    return (i == 0) ? o0 : ((i == 1) ? o1 : o2);
  endfunction

  function automatic int act_cnt(int i);
    return (i == 0) ? int'(c0) : ((i == 1) ? int'(c1) : int'(c2));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_k[i] = -1;
        m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        logic [7:0] e;
        int ph;
        e = exp_out(i);
        ph = phase(i);
        if ((e[3] || (e[0] && !branch_taken)) && m_cnt[i] < cmax_of(i)) m_cnt[i]++;
        m_k[i] = (ph < 0 || ph == sw_of(i)) ? -1 : ph + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        logic [7:0] e;
        e = exp_out(i);
        checks++;
        if (act_out(i) !== e) begin
          errors++;
          $display("FAIL model_out dut%0d t=%0t: got %b expected %b", i, $time, act_out(i), e);
        end
        checks++;
        if (act_cnt(i) != m_cnt[i]) begin
          errors++;
          $display("FAIL model_cnt dut%0d t=%0t: got %0d expected %0d", i, $time, act_cnt(i), m_cnt[i]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic clr_in();
    id_src1 = '0; id_src2 = '0; ex_dest = '0; mem_dest = '0;
    id_src1_valid = 0; id_two_src = 0; ex_wb_en = 0; ex_mem_r_en = 0;
    mem_wb_en = 0; mem_access = 0; branch_taken = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    ex_dest = 4'd3; ex_wb_en = 1; ex_mem_r_en = 1; id_src1 = 4'd3; id_src1_valid = 1;
  endtask

  initial begin
    rst = 1;
    clr_in();
    #1;
    cmp_en = 1;

    // Reset with quiet inputs
    repeat (2) next_cycle();
    @(negedge clk);
    chk("reset_outputs", int'(o0), 0);
    chk("reset_cnt", int'(c0), 0);
    next_cycle();
    rst = 0;

    // SRAM wait sequence with mem_access held
    mem_access = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 4) chk($sformatf("sram_stall_c%0d", c), int'(o0[7:2]), 6'b101011);
      if (c == 4) begin
        chk("sram_done_freezes", int'(o0[7:2]), 0);
        chk("sram_done_pulse", int'(o0[1]), 1);
      end
      if (c == 5) begin
        chk("sram_restall", int'(o0[7:2]), 6'b101011);
        chk("stall_cnt_after_access", int'(c0), 4);
      end
      next_cycle();
    end
    // Reset mid-WAIT aborts the stall immediately
    rst = 1;
    @(negedge clk);
    chk("rst_mid_wait_freeze", int'(o0[3]), 0);
    next_cycle();
    rst = 0;
    mem_access = 0;
    @(negedge clk);
    chk("idle_after_rst", int'(o0), 0);
    next_cycle();

    // Load-use with forwarding
    set_load_use();
    @(negedge clk);
    chk("loaduse_if_freeze", int'(o0[7]), 1);
    chk("loaduse_id_flush", int'(o0[4]), 1);
    chk("loaduse_id_freeze", int'(o0[5]), 0);
    next_cycle();
    ex_mem_r_en = 0;
    @(negedge clk);
    chk("no_load_no_stall", int'(o0), 0);
    next_cycle();

    // MEM-stage hazard without forwarding
    clr_in();
    mem_dest = 4'd7; mem_wb_en = 1; id_two_src = 1; id_src2 = 4'd7;
    @(negedge clk);
    chk("nofwd_mem_hazard", int'(o1[0]), 1);
    chk("fwd_ignores_mem", int'(o0[0]), 0);
    next_cycle();
    id_two_src = 0;
    @(negedge clk);
    chk("nofwd_no_src2", int'(o1[0]), 0);
    next_cycle();

    // Branch overrides hazard
    clr_in();
    set_load_use();
    branch_taken = 1;
    @(negedge clk);
    chk("br_hz_if_flush", int'(o0[6]), 1);
    chk("br_hz_id_flush", int'(o0[4]), 1);
    chk("br_hz_if_freeze", int'(o0[7]), 0);
    next_cycle();

    // Branch held during a stall acts on the done cycle
    clr_in();
    rst = 1;
    next_cycle();
    rst = 0;
    mem_access = 1;
    branch_taken = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 4) chk($sformatf("br_stall_noflush_c%0d", c), int'(o0[7:6]), 2'b10);
      else       chk("br_on_done", int'({o0[6], o0[4], o0[1]}), 3'b111);
      next_cycle();
      mem_access = 0;
    end
    clr_in();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      id_src1 = 4'($urandom_range(0, 3));
      id_src2 = 4'($urandom_range(0, 3));
      ex_dest = 4'($urandom_range(0, 3));
      mem_dest = 4'($urandom_range(0, 3));
      id_src1_valid = 1'($urandom_range(0, 1));
      id_two_src = 1'($urandom_range(0, 1));
      ex_wb_en = 1'($urandom_range(0, 1));
      ex_mem_r_en = 1'($urandom_range(0, 1));
      mem_wb_en = 1'($urandom_range(0, 1));
      mem_access = ($urandom_range(0, 9) < 3);
      branch_taken = ($urandom_range(0, 9) < 2);
      rst = ($urandom_range(0, 99) == 0);
      next_cycle();
    end

    // Narrow counter must saturate
    clr_in();
    rst = 0;
    mem_access = 1;
    repeat (20) next_cycle();
    @(negedge clk);
    chk("cnt_saturates", int'(c2), 7);
    next_cycle();

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
